// File: rtl/irq_seq_pkg.sv
// irq_seq_pkg: shared state encodings, datapath select codes, MOVS decode
// pattern and control-word helpers for the interrupt sequencer.
package irq_seq_pkg;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'd0,
        ST_FETCH    = 5'd1,
        ST_DECODE   = 5'd2,
        ST_EXEC     = 5'd3,
        ST_MOVS_ALU = 5'd4,
        ST_MOVS_POP = 5'd5,
        ST_MOVS_RET = 5'd6,
        ST_INT_PUSH = 5'd7,
        ST_INT_SAVE = 5'd8,
        ST_INT_VEC  = 5'd9
    } state_t;

    // PC source selects
    localparam logic [3:0] PC_S_SEQ = 4'd0;
    localparam logic [3:0] PC_S_POP = 4'd1;
    localparam logic [3:0] PC_S_VEC = 4'd2;

    // CPSR write source selects
    localparam logic [2:0] W_CPSR_S_SPSR = 3'b000;
    localparam logic [2:0] W_CPSR_S_IRQ  = 3'b010;

    // ALU operation used by the MOVS return path
    localparam logic [3:0] ALU_OP_MOVS = 4'b1000;

    // MOVS PC,... decode pattern: opcode field IR[27:20] and Rd field IR[15:12]
    localparam logic [7:0] MOVS_OPCODE = 8'h1B;
    localparam logic [3:0] MOVS_RD     = 4'hF;

    typedef struct packed {
        logic       write_pc;
        logic       write_ir;
        logic       write_cpsr;
        logic       s;
        logic       sp_in;
        logic       sp_out;
        logic [3:0] pc_s;
        logic [2:0] w_cpsr_s;
        logic [3:0] alu_op;
    } ctrl_t;

    // Width of an interrupt index (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a priority limit, which must be able to hold n itself
    function automatic int lim_width(input int n);
        return $clog2(n + 1);
    endfunction

    // True when the opcode/Rd fields describe a MOVS into the PC
    function automatic logic is_movs(input logic [7:0] opcode, input logic [3:0] rd);
        return (opcode == MOVS_OPCODE) && (rd == MOVS_RD);
    endfunction

    // Datapath control word asserted while the sequencer sits in a state
    function automatic ctrl_t ctrl_for(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.write_pc = 1'b1;
                c.pc_s     = PC_S_SEQ;
                c.write_ir = 1'b1;
            end
            ST_MOVS_ALU: begin
                c.alu_op = ALU_OP_MOVS;
                c.s      = 1'b1;
            end
            ST_MOVS_POP: begin
                c.write_cpsr = 1'b1;
                c.w_cpsr_s   = W_CPSR_S_SPSR;
                c.pc_s       = PC_S_POP;
                c.sp_out     = 1'b1;
            end
            ST_MOVS_RET: c.sp_in = 1'b1;
            ST_INT_PUSH: c.sp_in = 1'b1;
            ST_INT_SAVE: begin
                c.write_cpsr = 1'b1;
                c.w_cpsr_s   = W_CPSR_S_IRQ;
            end
            ST_INT_VEC: begin
                c.write_pc = 1'b1;
                c.pc_s     = PC_S_VEC;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority request selector (bit 0 highest) with a
// priority ceiling, plus vector address computation for the winner.
module irq_prio_enc
    import irq_seq_pkg::*;
#(
    parameter int          N_IRQ      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic [N_IRQ-1:0]            req,
    input  logic                        mask,
    input  logic [lim_width(N_IRQ)-1:0] limit,
    output logic                        valid,
    output logic [idx_width(N_IRQ)-1:0] index,
    output logic [31:0]                 vector
);

    localparam int IDX_W = idx_width(N_IRQ);

    // Scan from the lowest priority upward so the lowest admitted index wins
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i] && !mask && (i < int'(limit))) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

    // Vector address wraps in 32-bit unsigned arithmetic
    always_comb begin
        vector = VEC_BASE + 32'(index) * VEC_STRIDE;
    end

endmodule

// File: rtl/irq_seq_ctrl.sv
// irq_seq_ctrl: instruction sequencer with interrupt entry/return handling.
// Optional feature macro IRQ_NEST_EN: when defined, a NEST_DEPTH-deep
// in-service priority stack allows higher-priority requests to preempt an
// ISR; when undefined, a single in-service flag blocks all requests.
module irq_seq_ctrl
    import irq_seq_pkg::*;
#(
    parameter int          N_IRQ      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE = 4,
    parameter int          NEST_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      IR,
    input  logic [N_IRQ-1:0] irq_req,
    input  logic             cpsr_i,
    output logic             Write_PC,
    output logic             Write_IR,
    output logic             Write_CPSR,
    output logic             S,
    output logic             SP_in,
    output logic             SP_out,
    output logic [3:0]       PC_s,
    output logic [2:0]       W_CPSR_s,
    output logic [3:0]       ALU_OP,
    output logic [4:0]       ST,
    output logic [N_IRQ-1:0] irq_ack,
    output logic [31:0]      vec_addr,
    output logic             in_isr
);

    localparam int IDX_W = idx_width(N_IRQ);
    localparam int LIM_W = lim_width(N_IRQ);

    if (NEST_DEPTH < 1) begin : g_bad_depth
        $error("irq_seq_ctrl: NEST_DEPTH must be at least 1");
    end

    state_t           st;
    state_t           st_nxt;
    ctrl_t            ctrl;
    logic             accept;
    logic             pop;
    logic [IDX_W-1:0] win_idx;
    logic [LIM_W-1:0] isr_limit;
    logic             enc_valid;
    logic [IDX_W-1:0] enc_index;
    logic [31:0]      enc_vector;
    logic             unused_ir;

    // Only the opcode and Rd fields matter for sequencing
    assign unused_ir = ^{IR[31:28], IR[19:16], IR[11:0]};

    irq_prio_enc #(
        .N_IRQ      (N_IRQ),
        .VEC_BASE   (VEC_BASE),
        .VEC_STRIDE (VEC_STRIDE)
    ) u_prio_enc (
        .req    (irq_req),
        .mask   (cpsr_i),
        .limit  (isr_limit),
        .valid  (enc_valid),
        .index  (enc_index),
        .vector (enc_vector)
    );

    assign pop = (st == ST_MOVS_POP);

`ifdef IRQ_NEST_EN
    localparam int CNT_W = $clog2(NEST_DEPTH + 1);

    logic [IDX_W-1:0] isr_stack [NEST_DEPTH];
    logic [CNT_W-1:0] isr_cnt;

    // Top of stack (entry 0) caps admissible priority; a full stack admits nothing
    always_comb begin
        if (isr_cnt == '0)
            isr_limit = LIM_W'(N_IRQ);
        else if (isr_cnt == CNT_W'(NEST_DEPTH))
            isr_limit = '0;
        else
            isr_limit = LIM_W'(isr_stack[0]);
    end

    // Shift-register stack: push on acceptance, pop on MOVS return
    always_ff @(posedge clk) begin
        if (rst) begin
            isr_cnt <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) isr_stack[i] <= '0;
        end else if (accept) begin
            for (int i = NEST_DEPTH - 1; i > 0; i--) isr_stack[i] <= isr_stack[i-1];
            isr_stack[0] <= enc_index;
            isr_cnt      <= isr_cnt + 1'b1;
        end else if (pop && (isr_cnt != '0)) begin
            for (int i = 0; i < NEST_DEPTH - 1; i++) isr_stack[i] <= isr_stack[i+1];
            isr_stack[NEST_DEPTH-1] <= '0;
            isr_cnt                 <= isr_cnt - 1'b1;
        end
    end

    assign in_isr = (isr_cnt != '0);
`else
    logic isr_flag;

    // Any interrupt in service blocks all further requests
    always_comb begin
        isr_limit = isr_flag ? '0 : LIM_W'(N_IRQ);
    end

    // Single in-service flag: set on acceptance, cleared on MOVS return
    always_ff @(posedge clk) begin
        if (rst)
            isr_flag <= 1'b0;
        else if (accept)
            isr_flag <= 1'b1;
        else if (pop)
            isr_flag <= 1'b0;
    end

    assign in_isr = isr_flag;
`endif

    // Next-state selection; interrupts are only considered at EXEC and MOVS_RET
    always_comb begin
        st_nxt = ST_FETCH;
        accept = 1'b0;
        case (st)
            ST_IDLE:     st_nxt = ST_FETCH;
            ST_FETCH:    st_nxt = ST_DECODE;
            ST_DECODE:   st_nxt = is_movs(IR[27:20], IR[15:12]) ? ST_MOVS_ALU : ST_EXEC;
            ST_EXEC, ST_MOVS_RET: begin
                if (enc_valid) begin
                    accept = 1'b1;
                    st_nxt = ST_INT_PUSH;
                end
            end
            ST_MOVS_ALU: st_nxt = ST_MOVS_POP;
            ST_MOVS_POP: st_nxt = ST_MOVS_RET;
            ST_INT_PUSH: st_nxt = ST_INT_SAVE;
            ST_INT_SAVE: st_nxt = ST_INT_VEC;
            ST_INT_VEC:  st_nxt = ST_FETCH;
            default:     st_nxt = ST_FETCH;
        endcase
    end

    // State register with control word, vector and acknowledge registered alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ST_IDLE;
            ctrl     <= '0;
            win_idx  <= '0;
            vec_addr <= '0;
            irq_ack  <= '0;
        end else begin
            st   <= st_nxt;
            ctrl <= ctrl_for(st_nxt);
            if (accept) begin
                win_idx  <= enc_index;
                vec_addr <= enc_vector;
            end
            irq_ack <= (st_nxt == ST_INT_VEC) ? (N_IRQ'(1) << win_idx) : '0;
        end
    end

    assign ST         = st;
    assign Write_PC   = ctrl.write_pc;
    assign Write_IR   = ctrl.write_ir;
    assign Write_CPSR = ctrl.write_cpsr;
    assign S          = ctrl.s;
    assign SP_in      = ctrl.sp_in;
    assign SP_out     = ctrl.sp_out;
    assign PC_s       = ctrl.pc_s;
    assign W_CPSR_s   = ctrl.w_cpsr_s;
    assign ALU_OP     = ctrl.alu_op;

endmodule

// File: tb/tb_irq_seq_ctrl.sv
// tb_irq_seq_ctrl: directed self-checking bench for irq_seq_ctrl.
// Expectations for preemption follow the IRQ_NEST_EN build setting.
module tb_irq_seq_ctrl;

    localparam logic [31:0] PLAIN = 32'hE081_1002;
    localparam logic [31:0] MOVS  = 32'hE1B0_F00E;
    localparam logic [31:0] NEAR  = 32'hE1B0_100E;

    logic        clk;
    logic        rst;
    logic [31:0] IR;
    logic [3:0]  irq_req;
    logic        cpsr_i;
    logic        Write_PC, Write_IR, Write_CPSR, S, SP_in, SP_out;
    logic [3:0]  PC_s;
    logic [2:0]  W_CPSR_s;
    logic [3:0]  ALU_OP;
    logic [4:0]  ST;
    logic [3:0]  irq_ack;
    logic [31:0] vec_addr;
    logic        in_isr;
    logic [16:0] ctrl_obs;

    int checks = 0;
    int errors = 0;

    irq_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .IR         (IR),
        .irq_req    (irq_req),
        .cpsr_i     (cpsr_i),
        .Write_PC   (Write_PC),
        .Write_IR   (Write_IR),
        .Write_CPSR (Write_CPSR),
        .S          (S),
        .SP_in      (SP_in),
        .SP_out     (SP_out),
        .PC_s       (PC_s),
        .W_CPSR_s   (W_CPSR_s),
        .ALU_OP     (ALU_OP),
        .ST         (ST),
        .irq_ack    (irq_ack),
        .vec_addr   (vec_addr),
        .in_isr     (in_isr)
    );

    assign ctrl_obs = {Write_PC, Write_IR, Write_CPSR, S, SP_in, SP_out, PC_s, W_CPSR_s, ALU_OP};

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Control word required in each state: {Write_PC,Write_IR,Write_CPSR,S,SP_in,SP_out,PC_s,W_CPSR_s,ALU_OP}
    function automatic logic [16:0] expCtrl(input int s);
        case (s)
            1:       return {6'b110000, 4'h0, 3'b000, 4'b0000};
            4:       return {6'b000100, 4'h0, 3'b000, 4'b1000};
            5:       return {6'b001001, 4'h1, 3'b000, 4'b0000};
            6:       return {6'b000010, 4'h0, 3'b000, 4'b0000};
            7:       return {6'b000010, 4'h0, 3'b000, 4'b0000};
            8:       return {6'b001000, 4'h0, 3'b010, 4'b0000};
            9:       return {6'b100000, 4'h2, 3'b000, 4'b0000};
            default: return 17'h0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [31:0] ir_v, input logic [3:0] req_v, input logic ci_v);
        IR      = ir_v;
        irq_req = req_v;
        cpsr_i  = ci_v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag, input int exp_st);
        checkOutput({tag, "_st"}, 32'(ST), 32'(exp_st));
        checkOutput({tag, "_ctrl"}, 32'(ctrl_obs), 32'(expCtrl(exp_st)));
    endtask

    // Walk a MOVS PC return from FETCH back to FETCH with no request pending
    task automatic returnFromIsr(input string tag, input logic isr_after);
        applyStimulus(MOVS, 4'b0000, 1'b0); checkState({tag, "_dec"}, 2);
        applyStimulus(MOVS, 4'b0000, 1'b0); checkState({tag, "_alu"}, 4);
        applyStimulus(MOVS, 4'b0000, 1'b0); checkState({tag, "_pop"}, 5);
        applyStimulus(MOVS, 4'b0000, 1'b0); checkState({tag, "_ret"}, 6);
        checkOutput({tag, "_in_isr"}, 32'(in_isr), 32'(isr_after));
        applyStimulus(MOVS, 4'b0000, 1'b0); checkState({tag, "_fetch"}, 1);
    endtask

    // Directed scenario sequence
    initial begin
        rst = 1'b1;
        applyStimulus(PLAIN, 4'b0000, 1'b0);
        applyStimulus(PLAIN, 4'b0000, 1'b0);
        checkState("reset", 0);
        checkOutput("reset_in_isr", 32'(in_isr), 32'd0);
        checkOutput("reset_ack", 32'(irq_ack), 32'd0);
        checkOutput("reset_vec", vec_addr, 32'd0);

        // Plain instruction, no interrupts
        rst = 1'b0;
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("plain_fetch", 1);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("plain_decode", 2);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("plain_exec", 3);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("plain_fetch2", 1);

        // Opcode matches MOVS but Rd is not the PC
        applyStimulus(NEAR, 4'b0000, 1'b0); checkState("near_decode", 2);
        applyStimulus(NEAR, 4'b0000, 1'b0); checkState("near_exec", 3);
        applyStimulus(NEAR, 4'b0000, 1'b0); checkState("near_fetch", 1);

        // Request that vanishes before the boundary is ignored
        applyStimulus(PLAIN, 4'b0001, 1'b0); checkState("glitch_decode", 2);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("glitch_exec", 3);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("glitch_fetch", 1);
        checkOutput("glitch_in_isr", 32'(in_isr), 32'd0);

        // Two requests at EXEC: line 1 wins, vector 0x104
        applyStimulus(PLAIN, 4'b0110, 1'b0); checkState("l1_decode", 2);
        applyStimulus(PLAIN, 4'b0110, 1'b0); checkState("l1_exec", 3);
        applyStimulus(PLAIN, 4'b0110, 1'b0); checkState("l1_push", 7);
        checkOutput("l1_vec", vec_addr, 32'h0000_0104);
        checkOutput("l1_in_isr", 32'(in_isr), 32'd1);
        checkOutput("l1_ack_push", 32'(irq_ack), 32'd0);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("l1_save", 8);
        checkOutput("l1_ack_save", 32'(irq_ack), 32'd0);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("l1_vec_st", 9);
        checkOutput("l1_ack_vec", 32'(irq_ack), 32'b0010);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("l1_fetch", 1);
        checkOutput("l1_ack_after", 32'(irq_ack), 32'd0);
        returnFromIsr("l1_ret", 1'b0);

        // Masked by CPSR I, then taken once unmasked
        applyStimulus(PLAIN, 4'b0001, 1'b1); checkState("mask_decode", 2);
        applyStimulus(PLAIN, 4'b0001, 1'b1); checkState("mask_exec", 3);
        applyStimulus(PLAIN, 4'b0001, 1'b1); checkState("mask_fetch", 1);
        applyStimulus(PLAIN, 4'b0001, 1'b0); checkState("unmask_decode", 2);
        applyStimulus(PLAIN, 4'b0001, 1'b0); checkState("unmask_exec", 3);
        applyStimulus(PLAIN, 4'b0001, 1'b0); checkState("unmask_push", 7);
        checkOutput("unmask_vec", vec_addr, 32'h0000_0100);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("unmask_save", 8);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("unmask_vec_st", 9);
        checkOutput("unmask_ack", 32'(irq_ack), 32'b0001);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("unmask_fetch", 1);
        returnFromIsr("l0_ret", 1'b0);

        // Enter ISR for line 2
        applyStimulus(PLAIN, 4'b0100, 1'b0); checkState("l2_decode", 2);
        applyStimulus(PLAIN, 4'b0100, 1'b0); checkState("l2_exec", 3);
        applyStimulus(PLAIN, 4'b0100, 1'b0); checkState("l2_push", 7);
        checkOutput("l2_vec", vec_addr, 32'h0000_0108);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("l2_save", 8);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("l2_vec_st", 9);
        checkOutput("l2_ack", 32'(irq_ack), 32'b0100);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("l2_fetch", 1);

        // Line 0 raised inside the line-2 ISR
        applyStimulus(PLAIN, 4'b0001, 1'b0); checkState("pre_decode", 2);
        applyStimulus(PLAIN, 4'b0001, 1'b0); checkState("pre_exec", 3);
`ifdef IRQ_NEST_EN
        applyStimulus(PLAIN, 4'b0001, 1'b0); checkState("nest_push", 7);
        checkOutput("nest_vec", vec_addr, 32'h0000_0100);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("nest_save", 8);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("nest_vec_st", 9);
        checkOutput("nest_ack", 32'(irq_ack), 32'b0001);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("nest_fetch", 1);
        returnFromIsr("nest_ret0", 1'b1);
        returnFromIsr("nest_ret2", 1'b0);
`else
        applyStimulus(PLAIN, 4'b0001, 1'b0); checkState("block_fetch", 1);
        checkOutput("block_in_isr", 32'(in_isr), 32'd1);
        applyStimulus(MOVS, 4'b0001, 1'b0); checkState("tail_decode", 2);
        applyStimulus(MOVS, 4'b0001, 1'b0); checkState("tail_alu", 4);
        applyStimulus(MOVS, 4'b0001, 1'b0); checkState("tail_pop", 5);
        applyStimulus(MOVS, 4'b0001, 1'b0); checkState("tail_ret", 6);
        checkOutput("tail_in_isr_ret", 32'(in_isr), 32'd0);
        applyStimulus(MOVS, 4'b0001, 1'b0); checkState("tail_push", 7);
        checkOutput("tail_vec", vec_addr, 32'h0000_0100);
        checkOutput("tail_in_isr", 32'(in_isr), 32'd1);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("tail_save", 8);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("tail_vec_st", 9);
        checkOutput("tail_ack", 32'(irq_ack), 32'b0001);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("tail_fetch", 1);
        returnFromIsr("tail_ret0", 1'b0);
`endif

        // Reset in INT_SAVE aborts the entry without an acknowledge
        applyStimulus(PLAIN, 4'b0010, 1'b0); checkState("rs_decode", 2);
        applyStimulus(PLAIN, 4'b0010, 1'b0); checkState("rs_exec", 3);
        applyStimulus(PLAIN, 4'b0010, 1'b0); checkState("rs_push", 7);
        applyStimulus(PLAIN, 4'b0010, 1'b0); checkState("rs_save", 8);
        rst = 1'b1;
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("rs_idle", 0);
        checkOutput("rs_in_isr", 32'(in_isr), 32'd0);
        checkOutput("rs_ack", 32'(irq_ack), 32'd0);
        checkOutput("rs_vec", vec_addr, 32'd0);
        rst = 1'b0;
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("rs_fetch", 1);
        checkOutput("rs_ack_f", 32'(irq_ack), 32'd0);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("rs_decode2", 2);
        checkOutput("rs_ack_d", 32'(irq_ack), 32'd0);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("rs_exec2", 3);
        checkOutput("rs_ack_e", 32'(irq_ack), 32'd0);
        applyStimulus(PLAIN, 4'b0000, 1'b0); checkState("rs_fetch2", 1);
        checkOutput("rs_in_isr2", 32'(in_isr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
